// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder.
package dmem_pkg;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_t;

    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_0064;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    function automatic int word_idx_w(input int depth);
        return $clog2(depth);
    endfunction

    // Misaligned or beyond the last word of the array.
    function automatic logic addr_err(input logic [31:0] addr, input int depth);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= 32'(depth));
    endfunction

endpackage

// File: rtl/dmem_if.sv
// CPU load/store port: request and response handshakes.
interface dmem_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        input  req_ready, resp_valid, resp_rdata, resp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_be, resp_ready,
        output req_ready, resp_valid, resp_rdata, resp_err
    );
endinterface

// File: rtl/dmem_array.sv
// Single-port word RAM with byte-write mask; no storage reset.
// Latency: read data registered, valid the cycle after en.
// Backpressure: none, one read or write per enabled cycle.
module dmem_array #(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = 8
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int b = 0; b < 4; b++) begin
                    if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end else begin
                rdata <= mem[idx];
            end
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, WAIT_CYCLES wait states, tohost capture.
// Latency: response valid WAIT_CYCLES+1 cycles after the handshake cycle.
// Backpressure: response held stable until resp_ready; no new request until the cycle after.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] TOHOST_ADDR = TOHOST_ADDR_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    dmem_if.slave       bus,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
);

    localparam int IDX_W = word_idx_w(DEPTH_WORDS);

    dmem_state_t state_q, state_nxt;
    dmem_req_t   req_q, live_req, cur_req;
    logic        err_q, cur_err;
    logic [3:0]  wait_cnt;
    logic        accept, commit, arr_en;
    logic [31:0] arr_rdata;

    assign live_req = '{we: bus.req_we, addr: bus.req_addr, wdata: bus.req_wdata, be: bus.req_be};
    assign accept   = (state_q == IDLE) && bus.req_valid;

    // With no wait states the array is accessed on the acceptance edge, so use the live request.
    assign cur_req = (state_q == IDLE) ? live_req : req_q;
    assign cur_err = (state_q == IDLE) ? addr_err(live_req.addr, DEPTH_WORDS) : err_q;
    assign commit  = (WAIT_CYCLES == 0) ? accept : ((state_q == WAIT) && (wait_cnt == 4'd1));
    assign arr_en  = commit && !cur_err;

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            IDLE: if (accept) state_nxt = (WAIT_CYCLES == 0) ? RESP : WAIT;
            WAIT: if (wait_cnt == 4'd1) state_nxt = RESP;
            RESP: if (bus.resp_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            req_q        <= '0;
            err_q        <= 1'b0;
            wait_cnt     <= 4'd0;
            tohost_valid <= 1'b0;
            tohost_data  <= 32'd0;
        end else begin
            state_q <= state_nxt;
            if (accept) begin
                req_q    <= live_req;
                err_q    <= addr_err(live_req.addr, DEPTH_WORDS);
                wait_cnt <= 4'(WAIT_CYCLES);
            end else if (state_q == WAIT) begin
                wait_cnt <= wait_cnt - 4'd1;
            end
            if (arr_en && cur_req.we && (cur_req.addr == TOHOST_ADDR) && (cur_req.be == 4'hF)) begin
                tohost_valid <= 1'b1;
                tohost_data  <= cur_req.wdata;
            end
        end
    end

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .IDX_W       (IDX_W)
    ) u_array (
        .clk   (clk),
        .en    (arr_en),
        .we    (cur_req.we),
        .be    (cur_req.be),
        .idx   (cur_req.addr[IDX_W+1:2]),
        .wdata (cur_req.wdata),
        .rdata (arr_rdata)
    );

    assign bus.req_ready  = (state_q == IDLE);
    assign bus.resp_valid = (state_q == RESP);
    assign bus.resp_err   = (state_q == RESP) && err_q;
    assign bus.resp_rdata = ((state_q == RESP) && !req_q.we && !err_q) ? arr_rdata : 32'd0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder at default parameters.
module tb_dmem_responder;

    logic        clk;
    logic        reset;
    logic        tohost_valid;
    logic [31:0] tohost_data;
    int          checks;
    int          errors;

    dmem_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (256),
        .WAIT_CYCLES (2),
        .TOHOST_ADDR (32'h0000_0064)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus),
        .tohost_valid (tohost_valid),
        .tohost_data  (tohost_data)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Issue one request, wait for its response, then complete the response handshake.
    // lat counts cycles from the handshake cycle to the first cycle with resp_valid high.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] be, output logic [31:0] rdata, output logic err,
                          output int lat);
        int guard;
        guard = 0;
        bus.req_valid = 1'b1;
        bus.req_we    = we;
        bus.req_addr  = addr;
        bus.req_wdata = wdata;
        bus.req_be    = be;
        while (bus.req_ready !== 1'b1 && guard < 20) begin
            @(posedge clk); #1;
            guard++;
        end
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        lat = 1;
        while (bus.resp_valid !== 1'b1 && lat < 50) begin
            @(posedge clk); #1;
            lat++;
        end
        rdata = bus.resp_rdata;
        err   = bus.resp_err;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lat;

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b0;
        bus.req_valid  = 1'b0;
        bus.req_we     = 1'b0;
        bus.req_addr   = 32'd0;
        bus.req_wdata  = 32'd0;
        bus.req_be     = 4'h0;
        bus.resp_ready = 1'b0;

        @(posedge clk); #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_rdata", bus.resp_rdata, 32'd0);
        chk("rst_resp_err", 32'(bus.resp_err), 32'd0);
        chk("rst_tohost_valid", 32'(tohost_valid), 32'd0);
        chk("rst_tohost_data", tohost_data, 32'd0);
        reset = 1'b1;
        @(posedge clk); #1;

        // Known contents for the error and reset scenarios.
        do_req(1'b1, 32'h0, 32'hCAFE_F00D, 4'hF, rd, er, lat);
        chk("pre0_err", 32'(er), 32'd0);
        do_req(1'b1, 32'h20, 32'h1234_5678, 4'hF, rd, er, lat);
        chk("pre20_err", 32'(er), 32'd0);

        // Round trip and latency.
        do_req(1'b1, 32'h10, 32'hDEAD_BEEF, 4'hF, rd, er, lat);
        chk("st10_lat", 32'(lat), 32'd3);
        chk("st10_rdata", rd, 32'd0);
        chk("st10_err", 32'(er), 32'd0);
        chk("post_resp_req_ready", 32'(bus.req_ready), 32'd1);
        do_req(1'b0, 32'h10, 32'h0, 4'h0, rd, er, lat);
        chk("ld10_lat", 32'(lat), 32'd3);
        chk("ld10_rdata", rd, 32'hDEAD_BEEF);
        chk("ld10_err", 32'(er), 32'd0);

        // Byte enables.
        do_req(1'b1, 32'h14, 32'h1122_3344, 4'hF, rd, er, lat);
        do_req(1'b1, 32'h14, 32'hAABB_CCDD, 4'b0101, rd, er, lat);
        do_req(1'b0, 32'h14, 32'h0, 4'hF, rd, er, lat);
        chk("be_merge", rd, 32'h11BB_33DD);

        // Errors.
        do_req(1'b0, 32'h13, 32'h0, 4'h0, rd, er, lat);
        chk("misalign_err", 32'(er), 32'd1);
        chk("misalign_rdata", rd, 32'd0);
        do_req(1'b1, 32'h400, 32'h5555_5555, 4'hF, rd, er, lat);
        chk("oor_err", 32'(er), 32'd1);
        chk("oor_rdata", rd, 32'd0);
        do_req(1'b0, 32'h0, 32'h0, 4'h0, rd, er, lat);
        chk("word0_intact", rd, 32'hCAFE_F00D);
        chk("word0_err", 32'(er), 32'd0);

        // tohost capture.
        chk("tohost_pre", 32'(tohost_valid), 32'd0);
        do_req(1'b1, 32'h64, 32'd25, 4'hF, rd, er, lat);
        chk("tohost_valid", 32'(tohost_valid), 32'd1);
        chk("tohost_data", tohost_data, 32'd25);
        do_req(1'b1, 32'h64, 32'h0000_0099, 4'h1, rd, er, lat);
        chk("tohost_valid_sticky", 32'(tohost_valid), 32'd1);
        chk("tohost_data_partial", tohost_data, 32'd25);
        do_req(1'b0, 32'h64, 32'h0, 4'h0, rd, er, lat);
        chk("tohost_word", rd, 32'h0000_0099);

        // Backpressure: hold the response for five cycles.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b0;
        bus.req_addr  = 32'h10;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        for (int i = 0; i < 5; i++) begin
            chk("bp_resp_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_resp_rdata", bus.resp_rdata, 32'hDEAD_BEEF);
            chk("bp_req_ready", 32'(bus.req_ready), 32'd0);
            @(posedge clk); #1;
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("bp_idle_req_ready", 32'(bus.req_ready), 32'd1);
        chk("bp_idle_resp_valid", 32'(bus.resp_valid), 32'd0);

        // Reset during WAIT of a store.
        bus.req_valid = 1'b1;
        bus.req_we    = 1'b1;
        bus.req_addr  = 32'h20;
        bus.req_wdata = 32'hFFFF_FFFF;
        bus.req_be    = 4'hF;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        @(posedge clk); #1;
        chk("mid_wait_req_ready", 32'(bus.req_ready), 32'd0);
        reset = 1'b0;
        #1;
        chk("arst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("arst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("arst_tohost_valid", 32'(tohost_valid), 32'd0);
        chk("arst_tohost_data", tohost_data, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        do_req(1'b0, 32'h20, 32'h0, 4'h0, rd, er, lat);
        chk("discarded_store", rd, 32'h1234_5678);
        chk("after_rst_lat", 32'(lat), 32'd3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
